// File: rtl/data_ring_pkg.sv
// Shared types and sizing for the data ring controller and its output skid buffer.
package data_ring_pkg;
    localparam int MAX_TAPS  = 32;
    localparam int PTR_W     = 5;
    localparam int LEN_W     = 6;
    localparam int PAYLOAD_W = 34;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCEPT,
        S_READ,
        S_DONE
    } state_t;

    // Zero means one tap; anything beyond the ring size saturates.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] cfg);
        if (cfg == '0) begin
            return LEN_W'(1);
        end else if (cfg > LEN_W'(MAX_TAPS)) begin
            return LEN_W'(MAX_TAPS);
        end else begin
            return cfg;
        end
    endfunction
endpackage

// File: rtl/ring_out_skid.sv
// Two-entry fall-through buffer between the BRAM read pipeline and the tap stream.
module ring_out_skid
    import data_ring_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [PAYLOAD_W-1:0] i_data,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_data,
    input  logic                 i_ready,
    output logic [1:0]           o_count
);
    // Handshake: a word moves when valid and ready are both high at a rising edge;
    // o_valid/o_data hold until taken. The writer never pushes into a full buffer,
    // it budgets against o_count instead of a ready signal.
    logic [PAYLOAD_W-1:0] r_mem [2];
    logic                 r_rd_idx;
    logic                 r_wr_idx;
    logic [1:0]           r_count;
    logic                 w_push;
    logic                 w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign w_push  = i_valid && !((r_count == 2'd0) && i_ready);
    assign o_valid = (r_count != 2'd0) || i_valid;
    assign o_data  = (r_count != 2'd0) ? r_mem[r_rd_idx] : (i_valid ? i_data : '0);
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_idx <= 1'b0;
            r_wr_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_idx] <= i_data;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/data_ring_ctrl.sv
// Stores each AXI-Stream sample in a BRAM ring and replays the newest L words, newest first.
// Macro DATA_RING_CLEAR_EN zero-fills the ring at start; without it a fill count masks stale words.
module data_ring_ctrl
    import data_ring_pkg::*;
(
    input  logic        axis_clk,
    input  logic        axis_rst_n,
    input  logic        ap_start,
    output logic        ap_busy,
    output logic        ap_done,
    input  logic [5:0]  cfg_len,
    input  logic        ss_tvalid,
    input  logic [31:0] ss_tdata,
    input  logic        ss_tlast,
    output logic        ss_tready,
    output logic        x_tvalid,
    output logic [31:0] x_tdata,
    output logic        x_tlast,
    output logic        x_slast,
    input  logic        x_tready,
    output logic [3:0]  data_WE,
    output logic        data_EN,
    output logic [31:0] data_Di,
    output logic [31:0] data_A,
    input  logic [31:0] data_Do,
    output state_t      o_dbg_state
);
    state_t               r_state;
    state_t               w_next;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic                 r_slast;
    logic                 r_rd_pend;
    logic                 r_rd_pend_last;
    logic                 r_rd_pend_zero;
`ifndef DATA_RING_CLEAR_EN
    logic [LEN_W-1:0]     r_fill;
`endif
    logic [PTR_W-1:0]     w_last_ptr;
    logic                 w_cnt_last;
    logic                 w_issue;
    logic                 w_rd_zero;
    logic                 w_last_hs;
    logic [1:0]           w_skid_count;
    logic [2:0]           w_occ;
    logic [PAYLOAD_W-1:0] w_push_data;
    logic [PAYLOAD_W-1:0] w_out_data;

    assign w_last_ptr = PTR_W'(r_len - 6'd1);
    assign w_cnt_last = (r_cnt == r_len - 6'd1);
    // BRAM data cannot be stalled, so a read goes out only if the skid can hold it next cycle.
    assign w_occ      = 3'(w_skid_count) + 3'(r_rd_pend);
    assign w_issue    = (r_state == S_READ) && (r_cnt < r_len) && (w_occ < 3'd2);
    assign w_last_hs  = (r_state == S_READ) && x_tvalid && x_tready && x_tlast;
`ifdef DATA_RING_CLEAR_EN
    assign w_rd_zero  = 1'b0;
`else
    assign w_rd_zero  = (r_cnt >= r_fill);
`endif

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ss_tready = 1'b0;
        ap_busy   = (r_state != S_IDLE);
        ap_done   = 1'b0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_Di   = 32'h0;
        data_A    = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
`ifdef DATA_RING_CLEAR_EN
                    w_next = S_CLEAR;
`else
                    w_next = S_ACCEPT;
`endif
                end
            end
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = {{(32-PTR_W){1'b0}}, r_cnt[PTR_W-1:0]};
                if (w_cnt_last) begin
                    w_next = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_Di = ss_tdata;
                    data_A  = {{(32-PTR_W){1'b0}}, r_wptr};
                    w_next  = S_READ;
                end
            end
            S_READ: begin
                if (w_issue && !w_rd_zero) begin
                    data_EN = 1'b1;
                    data_A  = {{(32-PTR_W){1'b0}}, r_rd_ptr};
                end
                if (w_last_hs) begin
                    w_next = r_slast ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_len          <= 6'd1;
            r_cnt          <= '0;
            r_wptr         <= '0;
            r_rd_ptr       <= '0;
            r_slast        <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            r_rd_pend_zero <= 1'b0;
`ifndef DATA_RING_CLEAR_EN
            r_fill         <= '0;
`endif
        end else begin
            r_rd_pend      <= w_issue;
            r_rd_pend_last <= w_cnt_last;
            r_rd_pend_zero <= w_rd_zero;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_len  <= eff_len(cfg_len);
                        r_wptr <= '0;
                        r_cnt  <= '0;
`ifndef DATA_RING_CLEAR_EN
                        r_fill <= '0;
`endif
                    end
                end
                S_CLEAR: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + 6'd1;
                end
                S_ACCEPT: begin
                    if (ss_tvalid) begin
                        r_slast  <= ss_tlast;
                        r_rd_ptr <= r_wptr;
                        r_cnt    <= '0;
`ifndef DATA_RING_CLEAR_EN
                        r_fill   <= (r_fill >= r_len) ? r_len : r_fill + 6'd1;
`endif
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_cnt    <= r_cnt + 6'd1;
                        r_rd_ptr <= (r_rd_ptr == '0) ? w_last_ptr : r_rd_ptr - 5'd1;
                    end
                    if (w_last_hs) begin
                        r_wptr <= (r_wptr == w_last_ptr) ? '0 : r_wptr + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_push_data = r_rd_pend ?
                         {r_slast, r_rd_pend_last, (r_rd_pend_zero ? 32'h0 : data_Do)} : '0;

    ring_out_skid u_skid (
        .i_clk   (axis_clk),
        .i_rst_n (axis_rst_n),
        .i_valid (r_rd_pend),
        .i_data  (w_push_data),
        .o_valid (x_tvalid),
        .o_data  (w_out_data),
        .i_ready (x_tready),
        .o_count (w_skid_count)
    );

    assign x_tdata     = w_out_data[31:0];
    assign x_tlast     = w_out_data[32];
    assign x_slast     = w_out_data[33];
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_data_ring_ctrl.sv
// Bench for data_ring_ctrl: BRAM model, directed runs with random data/backpressure,
// and a sample-history reference model of the expected taps and read addresses.
module tb_data_ring_ctrl;
    import data_ring_pkg::*;

`ifdef DATA_RING_CLEAR_EN
    localparam bit CLEAR_MODE = 1'b1;
`else
    localparam bit CLEAR_MODE = 1'b0;
`endif

    logic        axis_clk   = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        ap_start   = 1'b0;
    logic [5:0]  cfg_len    = 6'd0;
    logic        ss_tvalid  = 1'b0;
    logic [31:0] ss_tdata   = 32'h0;
    logic        ss_tlast   = 1'b0;
    logic        x_tready   = 1'b0;
    logic        ap_busy, ap_done, ss_tready;
    logic        x_tvalid, x_tlast, x_slast;
    logic [31:0] x_tdata;
    logic [3:0]  data_WE;
    logic        data_EN;
    logic [31:0] data_Di, data_A, data_Do;
    state_t      dbg_state;

    logic [31:0] mem [32];
    logic        preload_req = 1'b1;
    int          wr_cnt   = 0;
    int          addr_bad = 0;
    logic [4:0]  rd_q [$];

    logic [31:0] hist [$];
    logic [31:0] exp_q [$];
    logic [4:0]  exp_a [$];
    int          cur_len = 1;
    int          n_tests = 0;
    int          n_fail  = 0;

    data_ring_ctrl dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .ap_start    (ap_start),
        .ap_busy     (ap_busy),
        .ap_done     (ap_done),
        .cfg_len     (cfg_len),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .x_tvalid    (x_tvalid),
        .x_tdata     (x_tdata),
        .x_tlast     (x_tlast),
        .x_slast     (x_slast),
        .x_tready    (x_tready),
        .data_WE     (data_WE),
        .data_EN     (data_EN),
        .data_Di     (data_Di),
        .data_A      (data_A),
        .data_Do     (data_Do),
        .o_dbg_state (dbg_state)
    );

    always #5 axis_clk = ~axis_clk;

    // BRAM: one-cycle read latency, read-before-write, zero output when disabled.
    always @(posedge axis_clk) begin
        if (data_EN) begin
            data_Do <= mem[data_A[4:0]];
            for (int b = 0; b < 4; b++) begin
                if (data_WE[b]) mem[data_A[4:0]][8*b +: 8] <= data_Di[8*b +: 8];
            end
            if (data_WE == 4'hF) wr_cnt <= wr_cnt + 1;
            else if (data_WE == 4'h0) rd_q.push_back(data_A[4:0]);
            else addr_bad <= addr_bad + 1;
            if (data_A[31:5] != '0) addr_bad <= addr_bad + 1;
        end else begin
            data_Do <= 32'h0;
            if (data_WE != 4'h0) addr_bad <= addr_bad + 1;
        end
        if (preload_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ss_tready", ss_tready, 0);
        check("rst_x_tvalid", x_tvalid, 0);
        check("rst_x_tlast", x_tlast, 0);
        check("rst_x_slast", x_slast, 0);
        check("rst_x_tdata", x_tdata, 0);
        check("rst_ap_busy", ap_busy, 0);
        check("rst_ap_done", ap_done, 0);
        check("rst_data_EN", data_EN, 0);
        check("rst_data_WE", data_WE, 0);
        check("rst_data_Di", data_Di, 0);
        check("rst_data_A", data_A, 0);
        check("rst_state", dbg_state, S_IDLE);
    endtask

    task automatic start_run(input logic [5:0] cfg);
        int base;
        int g;
        cur_len = (cfg == 6'd0) ? 1 : (cfg > 6'd32) ? 32 : int'(cfg);
        hist.delete();
        @(negedge axis_clk);
        base     = wr_cnt;
        ap_start = 1'b1;
        cfg_len  = cfg;
        @(negedge axis_clk);
        ap_start = 1'b0;
        cfg_len  = 6'd0;
        check("busy_after_start", ap_busy, 1);
        g = 0;
        while (!ss_tready && g < 100) begin
            @(negedge axis_clk);
            g++;
        end
        check("accept_reached", ss_tready, 1);
        check("clear_writes", wr_cnt - base, CLEAR_MODE ? cur_len : 0);
    endtask

    // Expected taps: the newest cur_len samples of this run, newest first, zero before the run began.
    task automatic ss_handshake(input logic [31:0] d, input logic last);
        int  g;
        int  k;
        bit  hs;
        g = 0;
        hs = 0;
        rd_q.delete();
        hist.push_back(d);
        k = hist.size() - 1;
        exp_q.delete();
        exp_a.delete();
        for (int i = 0; i < cur_len; i++) begin
            exp_q.push_back(i <= k ? hist[k-i] : 32'h0);
            if (CLEAR_MODE || i <= k) exp_a.push_back(5'(((k - i) % cur_len + cur_len) % cur_len));
        end
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = last;
        while (!hs && g < 100) begin
            #1;
            hs = ss_tready;
            @(negedge axis_clk);
            g++;
        end
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        ss_tdata  = $urandom;
        check("ss_handshake", hs, 1);
    endtask

    task automatic collect_taps(input logic last, input bit rnd);
        int          n;
        int          cyc;
        int          first;
        bit          stall;
        logic [33:0] held;
        n = 0;
        cyc = 1;
        first = -1;
        stall = 0;
        held = '0;
        while (n < cur_len && cyc < 300) begin
            x_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall) check("stall_hold", {x_tvalid, x_slast, x_tlast, x_tdata}, {1'b1, held});
            if (x_tvalid && first < 0) first = cyc;
            if (x_tvalid && x_tready) begin
                check("tap_data", x_tdata, exp_q[n]);
                check("tap_last", x_tlast, (n == cur_len - 1));
                check("tap_slast", x_slast, last);
                n++;
            end
            stall = x_tvalid && !x_tready;
            held  = {x_slast, x_tlast, x_tdata};
            @(negedge axis_clk);
            cyc++;
        end
        check("tap_count", n, cur_len);
        check("first_tap_latency", first, 2);
        if (!rnd) check("throughput", cyc, cur_len + 2);
        check("no_extra_tap", x_tvalid, 0);
        check("done_pulse", ap_done, last);
        check("rd_count", rd_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < rd_q.size(); i++) check("rd_addr", rd_q[i], exp_a[i]);
        if (last) begin
            @(negedge axis_clk);
            check("done_one_cycle", ap_done, 0);
            check("idle_after_done", ap_busy, 0);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, input bit rnd);
        ss_handshake(d, last);
        collect_taps(last, rnd);
    endtask

    task automatic preload();
        @(negedge axis_clk);
        preload_req = 1'b1;
        @(negedge axis_clk);
        preload_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nrand;
        repeat (3) @(negedge axis_clk);
        preload_req = 1'b0;
        check_reset_outputs();
        axis_rst_n = 1'b1;

        // Basic run, L=4, full-rate consumer
        start_run(6'd4);
        send(32'd1, 1'b0, 1'b0);
        send(32'd2, 1'b0, 1'b0);
        send(32'd3, 1'b1, 1'b0);

        // Address wrap, L=3
        start_run(6'd3);
        for (int d = 10; d <= 15; d++) send(32'(d), (d == 15), 1'b0);

        // Random backpressure, with a stray ap_start while busy
        start_run(6'd4);
        ap_start = 1'b1;
        cfg_len  = 6'd2;
        @(negedge axis_clk);
        ap_start = 1'b0;
        cfg_len  = 6'd0;
        send(32'd1, 1'b0, 1'b1);
        send(32'd2, 1'b0, 1'b1);
        send(32'd3, 1'b1, 1'b1);

        // Random length and data under random backpressure
        start_run(6'($urandom_range(1, 31)));
        nrand = 5;
        for (int i = 0; i < nrand; i++) send($urandom, (i == nrand - 1), 1'b1);

        // Length clamping
        start_run(6'd0);
        send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b1, 1'b0);
        start_run(6'd40);
        send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b0, 1'b1);
        send($urandom, 1'b1, 1'b0);

        // Reset in the middle of a read burst
        start_run(6'd8);
        send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b0, 1'b0);
        ss_handshake($urandom, 1'b0);
        x_tready = 1'b1;
        repeat (3) @(negedge axis_clk);
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        check_reset_outputs();
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        start_run(6'd8);
        send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b1, 1'b1);

        // Stale BRAM contents must never reach the tap stream
        preload();
        start_run(6'd4);
        send(32'd5, 1'b1, 1'b0);

        check("bram_port_protocol", addr_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_ring_ctrl.md
DATA_RING_CTRL -- requirements
Module: data_ring_ctrl

Interface
REQ-001 SHALL have ports: axis_clk  in  1  sole clock; all logic rising-edge.
REQ-002 SHALL have ports: axis_rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: ap_start  in  1  one-cycle start pulse; ap_busy  out  1; ap_done  out  1  one-cycle done pulse.
REQ-004 SHALL have ports: cfg_len  in  6  tap count, sampled at accepted ap_start.
REQ-005 SHALL have ports: ss_tvalid  in  1; ss_tdata  in  32; ss_tlast  in  1; ss_tready  out  1  (AXI-Stream sample input).
REQ-006 SHALL have ports: x_tvalid  out  1; x_tdata  out  32; x_tlast  out  1  (last tap of a sample); x_slast  out  1  (sample carried ss_tlast); x_tready  in  1.
REQ-007 SHALL have data-BRAM master ports: data_WE  out  4; data_EN  out  1; data_Di  out  32; data_A  out  32  (word index, bits [31:5] zero); data_Do  in  32  (1-cycle read latency, reads 0 when EN low, read-before-write).

Function
REQ-008 SHALL sample cfg_len at ap_start in IDLE only; 0 -> 1, >32 -> 32 (effective length L).
REQ-009 SHALL run states IDLE -> CLEAR -> ACCEPT -> READ -> (ACCEPT | DONE) -> IDLE.
REQ-010 SHALL in CLEAR write 0 (WE=4'hF, EN=1) to words 0..L-1, one per cycle, L cycles; wptr=0 on exit.
REQ-011 SHALL assert ss_tready only in ACCEPT; on handshake write ss_tdata to word wptr with WE=4'hF same cycle, latch ss_tlast, enter READ next cycle.
REQ-012 SHALL in READ issue L reads, addresses wptr, wptr-1, ... modulo L (newest first, wrap L-1 after 0).
REQ-013 SHALL present each read word on x_tdata with x_tvalid; x_tlast=1 on the L-th tap only; x_slast = latched ss_tlast on every tap of that sample.
REQ-014 SHALL sustain one tap per cycle when x_tready held high; first x_tvalid 2 cycles after ss handshake.
REQ-015 SHALL hold x_tvalid/x_tdata/x_tlast/x_slast stable while x_tready low; no tap lost or duplicated under any backpressure pattern.
REQ-016 SHALL never issue a read whose data cannot be stored (at most 2 taps in flight + buffered).
REQ-017 SHALL after last tap handshake advance wptr = (wptr+1) mod L; enter DONE if latched tlast else ACCEPT.
REQ-018 SHALL pulse ap_done one cycle in DONE; ap_busy = 1 in every state except IDLE.
REQ-019 SHALL ignore ap_start while busy; data_EN=0, data_WE=0 whenever no access.

Reset
REQ-020 SHALL on axis_rst_n low at a clock edge, regardless of state: state IDLE, wptr 0, buffers empty.
REQ-021 SHALL reset outputs: ss_tready, x_tvalid, x_tlast, x_slast, ap_busy, ap_done, data_EN = 0; data_WE = 0; x_tdata, data_Di, data_A = 0.
REQ-022 SHALL abort mid-CLEAR/READ on reset with no further BRAM access; BRAM content unspecified afterwards.

Configuration
REQ-023 SHALL support macro DATA_RING_CLEAR_EN: defined -> CLEAR state per REQ-010.
REQ-024 SHALL without DATA_RING_CLEAR_EN skip CLEAR (IDLE -> ACCEPT) and track fill count (saturating at L); taps older than fill count output 0 with data_EN=0 for that read; tap sequence identical to defined case.

Structure
REQ-025 SHALL place state enum, MAX_TAPS=32, PTR_W=5 in shared package data_ring_pkg.
REQ-026 SHALL implement output buffering in sub-module ring_out_skid (2-entry valid/ready skid buffer, 34-bit payload).

Verification
REQ-027 SHALL cover: DATA_RING_CLEAR_EN defined, cfg_len=4, samples 1,2,3 (3 with tlast), x_tready=1 -> taps 1,0,0,0 | 2,1,0,0 | 3,2,1,0; ap_done one cycle after last tap.
REQ-028 SHALL cover: cfg_len=3, samples 10..15 -> sample 15 yields 15,14,13, addresses wrap 2->1->0->2 correctly.
REQ-029 SHALL cover: cfg_len=4, x_tready random 50% -> identical tap sequence to REQ-027, stable x_tdata during stalls.
REQ-030 SHALL cover: cfg_len=0 and cfg_len=40 -> L=1 and L=32 respectively (taps per sample count).
REQ-031 SHALL cover: axis_rst_n low mid-READ of L=8 -> next cycle all outputs per REQ-021; new ap_start runs clean.
REQ-032 SHALL cover: without DATA_RING_CLEAR_EN, BRAM preloaded 32'hDEAD_BEEF, cfg_len=4, sample 5 -> taps 5,0,0,0 and no CLEAR writes.
